// File: rtl/ysyx_25060170_gpr_wb_arbiter.sv
// rtl/ysyx_25060170_gpr_wb_arbiter.sv - EXU/LSU writeback arbiter for the GPR write port with busy scoreboard
module ysyx_25060170_gpr_wb_arbiter #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    issue_valid,
   input  logic [$clog2(NREG)-1:0] issue_rd,
   output logic                    issue_ready,
   input  logic [$clog2(NREG)-1:0] rs1_addr,
   input  logic [$clog2(NREG)-1:0] rs2_addr,
   output logic                    rs1_busy,
   output logic                    rs2_busy,
   input  logic                    wb0_valid,
   input  logic [$clog2(NREG)-1:0] wb0_rd,
   input  logic [XLEN-1:0]         wb0_data,
   output logic                    wb0_ready,
   input  logic                    wb1_valid,
   input  logic [$clog2(NREG)-1:0] wb1_rd,
   input  logic [XLEN-1:0]         wb1_data,
   output logic                    wb1_ready,
   output logic                    GPR_we,
   output logic [$clog2(NREG)-1:0] GPR_writer,
   output logic [XLEN-1:0]         GPR_wd,
   output logic                    idle
);

   localparam int AW = $clog2(NREG);

   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nxt;
   logic            last_grant;
   logic            grant0;
   logic            grant1;
   logic            issue_fire;
   logic [AW-1:0]   sel_rd;
   logic [XLEN-1:0] sel_data;

   // Round-robin: on contention the requester that did not win last time is served.
   always_comb begin
      grant0 = wb0_valid & (~wb1_valid | last_grant);
      grant1 = wb1_valid & (~wb0_valid | ~last_grant);
   end

   always_comb begin
      sel_rd   = grant1 ? wb1_rd   : wb0_rd;
      sel_data = grant1 ? wb1_data : wb0_data;
   end

   assign wb0_ready   = grant0;
   assign wb1_ready   = grant1;
   assign issue_ready = ~busy[issue_rd] | (issue_rd == '0);
   assign issue_fire  = issue_valid & issue_ready & (issue_rd != '0);
   assign rs1_busy    = busy[rs1_addr];
   assign rs2_busy    = busy[rs2_addr];
   assign idle        = (busy == '0) & ~GPR_we;

   // Clear is applied before set so a same-index set on the commit edge survives.
   always_comb begin
      busy_nxt = busy;
      if (GPR_we)
         busy_nxt[GPR_writer] = 1'b0;
      if (issue_fire)
         busy_nxt[issue_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy       <= '0;
         last_grant <= 1'b1;
         GPR_we     <= 1'b0;
         GPR_writer <= '0;
         GPR_wd     <= '0;
      end else begin
         busy <= busy_nxt;
         if (grant0 | grant1) begin
            last_grant <= grant1;
            GPR_we     <= (sel_rd != '0);
            GPR_writer <= sel_rd;
            GPR_wd     <= sel_data;
         end else begin
            GPR_we <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_25060170_gpr_wb_arbiter.sv
// tb/tb_ysyx_25060170_gpr_wb_arbiter.sv - self-checking bench for the GPR writeback arbiter
module tb_ysyx_25060170_gpr_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        issue_valid = 1'b0;
   logic [4:0]  issue_rd = '0;
   logic        issue_ready;
   logic [4:0]  rs1_addr = '0;
   logic [4:0]  rs2_addr = '0;
   logic        rs1_busy;
   logic        rs2_busy;
   logic        wb0_valid = 1'b0;
   logic [4:0]  wb0_rd = '0;
   logic [31:0] wb0_data = '0;
   logic        wb0_ready;
   logic        wb1_valid = 1'b0;
   logic [4:0]  wb1_rd = '0;
   logic [31:0] wb1_data = '0;
   logic        wb1_ready;
   logic        GPR_we;
   logic [4:0]  GPR_writer;
   logic [31:0] GPR_wd;
   logic        idle;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ysyx_25060170_gpr_wb_arbiter #(.XLEN(32), .NREG(32)) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
      .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
      .GPR_we(GPR_we), .GPR_writer(GPR_writer), .GPR_wd(GPR_wd), .idle(idle)
   );

   // Reference model: a set of outstanding destinations plus the pending write slot.
   bit          m_busy [32];
   int          m_last;
   bit          m_we;
   logic [4:0]  m_writer;
   logic [31:0] m_wd;

   function automatic int exp_grant();
      if (wb0_valid && wb1_valid) return (m_last == 0) ? 1 : 0;
      if (wb0_valid) return 0;
      if (wb1_valid) return 1;
      return -1;
   endfunction

   function automatic bit exp_busy(input logic [4:0] a);
      return (a == 0) ? 1'b0 : m_busy[a];
   endfunction

   function automatic bit exp_issue_ready();
      return !exp_busy(issue_rd);
   endfunction

   function automatic bit exp_idle();
      for (int i = 1; i < 32; i++)
         if (m_busy[i]) return 1'b0;
      return !m_we;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) m_busy[i] <= 1'b0;
         m_last   <= 1;
         m_we     <= 1'b0;
         m_writer <= '0;
         m_wd     <= '0;
      end else begin
         if (m_we) m_busy[m_writer] <= 1'b0;
         if (issue_valid && exp_issue_ready() && issue_rd != 0) m_busy[issue_rd] <= 1'b1;
         if (exp_grant() == 0) begin
            m_last <= 0; m_we <= (wb0_rd != 0); m_writer <= wb0_rd; m_wd <= wb0_data;
         end else if (exp_grant() == 1) begin
            m_last <= 1; m_we <= (wb1_rd != 0); m_writer <= wb1_rd; m_wd <= wb1_data;
         end else begin
            m_we <= 1'b0;
         end
      end
   end

   task automatic clear_inputs();
      issue_valid = 0; wb0_valid = 0; wb1_valid = 0;
   endtask

   task automatic test_reset();
      rst = 1; clear_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 0; #1;
      checks++; if (GPR_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b expected 0", GPR_we); end
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b expected 1", idle); end
      for (int i = 0; i < 32; i++) begin
         issue_rd = 5'(i); rs1_addr = 5'(i); rs2_addr = 5'(31 - i); #1;
         checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready rd=%0d got %b expected 1", i, issue_ready); end
         checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin errors++; $display("FAIL reset_busy idx=%0d got %b%b expected 00", i, rs1_busy, rs2_busy); end
      end
   endtask

   task automatic test_issue_wb();
      @(negedge clk); issue_valid = 1; issue_rd = 5; rs1_addr = 5;
      @(negedge clk); issue_valid = 0;
      wb0_valid = 1; wb0_rd = 5; wb0_data = 32'h12345678; #1;
      checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL iw_busy_pre got %b expected 1", rs1_busy); end
      checks++; if (wb0_ready !== 1'b1) begin errors++; $display("FAIL iw_ready got %b expected 1", wb0_ready); end
      @(negedge clk); wb0_valid = 0; #1;
      checks++; if (GPR_we !== 1'b1 || GPR_writer !== 5'd5 || GPR_wd !== 32'h12345678) begin
         errors++; $display("FAIL iw_write got we=%b wr=%0d wd=%h expected 1 5 12345678", GPR_we, GPR_writer, GPR_wd); end
      checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL iw_busy_commit got %b expected 1", rs1_busy); end
      @(negedge clk); #1;
      checks++; if (rs1_busy !== 1'b0 || GPR_we !== 1'b0 || idle !== 1'b1) begin
         errors++; $display("FAIL iw_after got busy=%b we=%b idle=%b expected 0 0 1", rs1_busy, GPR_we, idle); end
   endtask

   task automatic test_contention();
      @(negedge clk); rst = 1; clear_inputs();
      @(negedge clk); rst = 0;
      wb0_valid = 1; wb0_rd = 3; wb0_data = 32'hAAAA_0003;
      wb1_valid = 1; wb1_rd = 4; wb1_data = 32'hBBBB_0004;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         checks++; if (wb0_ready !== (k % 2 == 0) || wb1_ready !== (k % 2 == 1)) begin
            errors++; $display("FAIL cont_grant k=%0d got %b%b expected %b%b", k, wb0_ready, wb1_ready, k % 2 == 0, k % 2 == 1); end
         if (k > 0) begin
            checks++; if (GPR_writer !== ((k % 2 == 1) ? 5'd3 : 5'd4)) begin
               errors++; $display("FAIL cont_writer k=%0d got %0d expected %0d", k, GPR_writer, (k % 2 == 1) ? 3 : 4); end
         end
      end
      @(negedge clk); clear_inputs(); #1;
      checks++; if (GPR_we !== 1'b1 || GPR_writer !== 5'd4 || GPR_wd !== 32'hBBBB_0004) begin
         errors++; $display("FAIL cont_last got we=%b wr=%0d wd=%h expected 1 4 bbbb0004", GPR_we, GPR_writer, GPR_wd); end
   endtask

   task automatic test_waw();
      @(negedge clk); issue_valid = 1; issue_rd = 7; rs1_addr = 7;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk); #1;
         checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL waw_stall k=%0d got %b expected 0", k, issue_ready); end
      end
      issue_valid = 0; wb0_valid = 1; wb0_rd = 7; wb0_data = 32'h7777;
      @(negedge clk); wb0_valid = 0; issue_valid = 1; #1;
      checks++; if (issue_ready !== 1'b0 || GPR_we !== 1'b1) begin
         errors++; $display("FAIL waw_commit got ready=%b we=%b expected 0 1", issue_ready, GPR_we); end
      @(negedge clk); issue_valid = 0; #1;
      checks++; if (rs1_busy !== 1'b0 || issue_ready !== 1'b1) begin
         errors++; $display("FAIL waw_cleared got busy=%b ready=%b expected 0 1", rs1_busy, issue_ready); end
      // Writeback to a non-busy x7, then re-issue x7 on the commit edge.
      wb0_valid = 1;
      @(negedge clk); wb0_valid = 0; issue_valid = 1; #1;
      checks++; if (GPR_we !== 1'b1 || GPR_writer !== 5'd7 || issue_ready !== 1'b1) begin
         errors++; $display("FAIL waw_same_pre got we=%b wr=%0d ready=%b expected 1 7 1", GPR_we, GPR_writer, issue_ready); end
      @(negedge clk); issue_valid = 0; #1;
      checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL waw_same_edge got %b expected 1", rs1_busy); end
      wb0_valid = 1;
      @(negedge clk); wb0_valid = 0;
      @(negedge clk); #1;
      checks++; if (rs1_busy !== 1'b0 || idle !== 1'b1) begin
         errors++; $display("FAIL waw_final got busy=%b idle=%b expected 0 1", rs1_busy, idle); end
   endtask

   task automatic test_x0();
      @(negedge clk); issue_valid = 1; issue_rd = 0; rs1_addr = 0; #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL x0_issue_ready got %b expected 1", issue_ready); end
      @(negedge clk); issue_valid = 0; #1;
      checks++; if (rs1_busy !== 1'b0 || idle !== 1'b1) begin
         errors++; $display("FAIL x0_busy got busy=%b idle=%b expected 0 1", rs1_busy, idle); end
      wb1_valid = 1; wb1_rd = 0; wb1_data = 32'hFFFF_FFFF; #1;
      checks++; if (wb1_ready !== 1'b1) begin errors++; $display("FAIL x0_wb_ready got %b expected 1", wb1_ready); end
      @(negedge clk); wb1_valid = 0; #1;
      checks++; if (GPR_we !== 1'b0 || idle !== 1'b1) begin
         errors++; $display("FAIL x0_we got we=%b idle=%b expected 0 1", GPR_we, idle); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk); issue_valid = 1; issue_rd = 9; rs1_addr = 9;
      @(negedge clk); issue_valid = 0; wb0_valid = 1; wb0_rd = 9; wb0_data = 32'hCAFE_0009; #1;
      checks++; if (wb0_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b expected 1", wb0_ready); end
      @(negedge clk); wb0_valid = 0; rst = 1; #1;
      checks++; if (GPR_we !== 1'b1) begin errors++; $display("FAIL rmid_we_pre got %b expected 1", GPR_we); end
      @(negedge clk); rst = 0; #1;
      checks++; if (GPR_we !== 1'b0 || rs1_busy !== 1'b0 || idle !== 1'b1) begin
         errors++; $display("FAIL rmid_after got we=%b busy=%b idle=%b expected 0 0 1", GPR_we, rs1_busy, idle); end
   endtask

   task automatic test_random();
      bit hold0 = 0;
      bit hold1 = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (!hold0) begin wb0_valid = 1'($urandom); wb0_rd = 5'($urandom_range(0, 7)); wb0_data = $urandom; end
         if (!hold1) begin wb1_valid = 1'($urandom); wb1_rd = 5'($urandom_range(0, 7)); wb1_data = $urandom; end
         issue_valid = 1'($urandom); issue_rd = 5'($urandom_range(0, 7));
         rs1_addr = 5'($urandom_range(0, 7)); rs2_addr = 5'($urandom_range(0, 7));
         #1;
         checks++; if (wb0_ready !== (exp_grant() == 0) || wb1_ready !== (exp_grant() == 1)) begin
            errors++; $display("FAIL rnd_grant c=%0d got %b%b expected grant %0d", c, wb0_ready, wb1_ready, exp_grant()); end
         checks++; if (issue_ready !== exp_issue_ready() || rs1_busy !== exp_busy(rs1_addr) || rs2_busy !== exp_busy(rs2_addr)) begin
            errors++; $display("FAIL rnd_sb c=%0d got %b%b%b expected %b%b%b", c, issue_ready, rs1_busy, rs2_busy,
                               exp_issue_ready(), exp_busy(rs1_addr), exp_busy(rs2_addr)); end
         checks++; if (GPR_we !== m_we || GPR_writer !== m_writer || GPR_wd !== m_wd || idle !== exp_idle()) begin
            errors++; $display("FAIL rnd_wport c=%0d got %b %0d %h %b expected %b %0d %h %b", c, GPR_we, GPR_writer, GPR_wd, idle,
                               m_we, m_writer, m_wd, exp_idle()); end
         hold0 = wb0_valid && (exp_grant() != 0);
         hold1 = wb1_valid && (exp_grant() != 1);
      end
      @(negedge clk); clear_inputs();
   endtask

   initial begin
      test_reset();
      test_issue_wb();
      test_contention();
      test_waw();
      test_x0();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
